wbcon_exec_pipe: RTL and testbench
==================================

# wbcon_exec_pipe

Pipelined Wishbone execution engine for the serial-stream Wishbone bridge: accepts decoded commands (set address, write word, read word), issues them as pipelined Wishbone transactions with up to `MAX_OUTSTANDING` in flight, and returns one in-order result per command. It sits between the command deserializer and the response serializer. It adds two things the single-transaction engine lacks: overlapping bus accesses and optional per-command address auto-increment.

## Interface
- `WB_ADDR_WIDTH`, 24, Wishbone word address width
- `WB_DATA_WIDTH`, 32, Wishbone data width
- `WB_SEL_WIDTH`, (WB_DATA_WIDTH+7)/8, byte-select width
- `BYTE_ADDR_WIDTH`, $clog2(WB_SEL_WIDTH), byte-offset bits in the serial address
- `SERIAL_ADDR_WIDTH`, WB_ADDR_WIDTH+BYTE_ADDR_WIDTH, command byte-address width
- `MAX_OUTSTANDING`, 4, power of 2, ≥2; in-flight plus queued-result credit limit
- `i_clk`  in  1  clock; single clock domain
- `i_rst_n`  in  1  synchronous active-low reset
- `i_cmd_tvalid` / `o_cmd_tready`  in/out  1  command handshake
- `i_cmd_op_set_address`, `i_cmd_op_write_word`, `i_cmd_op_read_word`  in  1 each  one-hot opcode
- `i_cmd_inc`  in  1  post-increment address after this read/write
- `i_cmd_hw_addr`  in  SERIAL_ADDR_WIDTH  byte address for set_address
- `i_cmd_hw_data`  in  WB_DATA_WIDTH  write data
- `o_cres_tvalid` / `i_cres_tready`  out/in  1  result handshake
- `o_cres_op_set_address`, `o_cres_op_write_word`, `o_cres_op_read_word`  out  1 each  echoed opcode
- `o_cres_hw_data`  out  WB_DATA_WIDTH  read data (0 for writes/set_address)
- `o_cres_bus_err`, `o_cres_bus_rty`  out  1 each  termination status
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each; `o_wb_adr`  out  WB_ADDR_WIDTH; `o_wb_dat`  out  WB_DATA_WIDTH; `o_wb_sel`  out  WB_SEL_WIDTH
- `i_wb_stall`, `i_wb_ack`, `i_wb_err`, `i_wb_rty`  in  1 each; `i_wb_dat`  in  WB_DATA_WIDTH

## Operation
- Address register `addr` (SERIAL_ADDR_WIDTH) is loaded by set_address. `o_wb_adr = addr[SERIAL_ADDR_WIDTH-1:BYTE_ADDR_WIDTH]` at issue. Byte bits are kept but do not affect the bus. `o_wb_sel` = all ones.
- Read/write with `i_cmd_inc=1`: `addr += 1<<BYTE_ADDR_WIDTH` on acceptance, wrapping modulo 2^SERIAL_ADDR_WIDTH.
- Credit = outstanding + result-FIFO occupancy. A read/write is accepted only when credit < MAX_OUTSTANDING and the stb slot is free (`!o_wb_stb || !i_wb_stall`).
- set_address is accepted only when outstanding==0 and `o_wb_stb==0` (pipeline drained) and the FIFO is not full. It pushes its result directly, so results stay in order.
- Tag FIFO (depth MAX_OUTSTANDING) records the opcode of each issued strobe. On ack/err/rty, pop the tag and push {op, data, err, rty} to the result FIFO. Results are strictly in order.
- Any of ack/err/rty terminates exactly one transaction. err and rty are reported, and later transactions continue.
- Terminations with outstanding==0 are ignored.
- Unrecognised or non-one-hot opcode: command is consumed and dropped, with no result.

## Timing
- Reset: all outputs 0, including `o_cmd_tready`, `o_cres_tvalid`, `o_wb_cyc/stb/we/adr/dat/sel`. `addr`=0, FIFOs and counters cleared. Reset asserted mid-cycle drops cyc/stb on the next edge; in-flight results are discarded.
- `o_cmd_tready` is combinational on opcode and credit; it depends only on tvalid content, not on downstream ready.
- Command accepted in cycle N → `o_wb_cyc`/`o_wb_stb`/`o_wb_adr`/`o_wb_we`/`o_wb_dat` valid in N+1. stb holds while `i_wb_stall`=1.
- Back-to-back issue: one strobe per cycle when no stall and credit remains.
- Termination in cycle M → `o_cres_tvalid` in M+1 (registered FIFO write). set_address accepted in N → result valid N+1.
- `o_wb_cyc` stays high while stb=1 or outstanding>0, and falls the cycle after the last termination unless a new command was accepted in that same cycle.
- Issue and termination in the same cycle leave outstanding unchanged.
- The result FIFO holds its head while `i_cres_tready`=0. The credit rule guarantees it never overflows.

## Test plan
- set_address 0x000010, then 3 reads with inc=1, zero-wait slave → adr 0x4, 0x5, 0x6 on consecutive cycles; 3 read results in order with the slave data; cyc drops after the 3rd ack.
- MAX_OUTSTANDING=4, slave acks 6 cycles late, 8 writes queued → at most 4 strobes before the first ack; 8 write results, err=rty=0.
- Stall high for 5 cycles on the first strobe → stb/adr/dat held stable, cmd_tready=0, no duplicate issue.
- Read terminated by err, next by rty, third by ack → results {err=1}, {rty=1}, {data}, in order.
- `i_cres_tready`=0 with 4 reads pending → after 4 results are queued cmd_tready=0; release → 4 results drain, issue resumes.
- `i_rst_n` low during an in-flight burst → next cycle cyc=stb=0, cres_tvalid=0; after release, set_address+read works normally.

Source files
------------

// File: rtl/wbcon_exec_pipe.sv
// Pipelined Wishbone execution engine: issues set-address/write/read commands as
// overlapping Wishbone transactions and returns one in-order result per command.
module wbcon_exec_pipe #(
    parameter int WB_ADDR_WIDTH     = 24,
    parameter int WB_DATA_WIDTH     = 32,
    parameter int WB_SEL_WIDTH      = (WB_DATA_WIDTH + 7) / 8,
    parameter int BYTE_ADDR_WIDTH   = $clog2(WB_SEL_WIDTH),
    parameter int SERIAL_ADDR_WIDTH = WB_ADDR_WIDTH + BYTE_ADDR_WIDTH,
    parameter int MAX_OUTSTANDING   = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_cmd_tvalid,
    output logic                         o_cmd_tready,
    input  logic                         i_cmd_op_set_address,
    input  logic                         i_cmd_op_write_word,
    input  logic                         i_cmd_op_read_word,
    input  logic                         i_cmd_inc,
    input  logic [SERIAL_ADDR_WIDTH-1:0] i_cmd_hw_addr,
    input  logic [WB_DATA_WIDTH-1:0]     i_cmd_hw_data,
    output logic                         o_cres_tvalid,
    input  logic                         i_cres_tready,
    output logic                         o_cres_op_set_address,
    output logic                         o_cres_op_write_word,
    output logic                         o_cres_op_read_word,
    output logic [WB_DATA_WIDTH-1:0]     o_cres_hw_data,
    output logic                         o_cres_bus_err,
    output logic                         o_cres_bus_rty,
    output logic                         o_wb_cyc,
    output logic                         o_wb_stb,
    output logic                         o_wb_we,
    output logic [WB_ADDR_WIDTH-1:0]     o_wb_adr,
    output logic [WB_DATA_WIDTH-1:0]     o_wb_dat,
    output logic [WB_SEL_WIDTH-1:0]      o_wb_sel,
    input  logic                         i_wb_stall,
    input  logic                         i_wb_ack,
    input  logic                         i_wb_err,
    input  logic                         i_wb_rty,
    input  logic [WB_DATA_WIDTH-1:0]     i_wb_dat
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [SERIAL_ADDR_WIDTH-1:0] ADDR_INC = SERIAL_ADDR_WIDTH'(1) << BYTE_ADDR_WIDTH;

    logic [SERIAL_ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]                r_out;
    logic                         r_tag_we [MAX_OUTSTANDING];
    logic [PW-1:0]                r_tag_wp, r_tag_rp;
    logic [2:0]                   r_res_op   [MAX_OUTSTANDING];
    logic [WB_DATA_WIDTH-1:0]     r_res_data [MAX_OUTSTANDING];
    logic                         r_res_err  [MAX_OUTSTANDING];
    logic                         r_res_rty  [MAX_OUTSTANDING];
    logic [PW-1:0]                r_res_wp, r_res_rp;
    logic [CW-1:0]                r_res_cnt;
    logic                         r_wb_cyc, r_wb_stb, r_wb_we;
    logic [WB_ADDR_WIDTH-1:0]     r_wb_adr;
    logic [WB_DATA_WIDTH-1:0]     r_wb_dat;
    logic [WB_SEL_WIDTH-1:0]      r_wb_sel;

    logic                     w_is_set, w_is_wr, w_is_rd, w_is_bad;
    logic [CW:0]              w_credit;
    logic                     w_acc, w_acc_set, w_acc_rw, w_term, w_term_we;
    logic                     w_push, w_pop, w_stb_next;
    logic [CW-1:0]            w_out_next;
    logic [2:0]               w_push_op;
    logic [WB_DATA_WIDTH-1:0] w_push_data;

    assign w_is_set  = i_cmd_op_set_address & ~i_cmd_op_write_word & ~i_cmd_op_read_word;
    assign w_is_wr   = ~i_cmd_op_set_address & i_cmd_op_write_word & ~i_cmd_op_read_word;
    assign w_is_rd   = ~i_cmd_op_set_address & ~i_cmd_op_write_word & i_cmd_op_read_word;
    assign w_is_bad  = ~(w_is_set | w_is_wr | w_is_rd);
    assign w_credit  = {1'b0, r_out} + {1'b0, r_res_cnt};
    assign w_term    = (i_wb_ack | i_wb_err | i_wb_rty) && (r_out != '0);
    assign w_term_we = r_tag_we[r_tag_rp];

    // Ready never looks at i_cres_tready; the credit count already covers result space.
    always_comb begin
        o_cmd_tready = 1'b0;
        if (i_rst_n) begin
            if (w_is_bad)
                o_cmd_tready = 1'b1;
            else if (w_is_set)
                o_cmd_tready = (r_out == '0) && !r_wb_stb && (r_res_cnt != CW'(MAX_OUTSTANDING));
            else
                o_cmd_tready = (w_credit < (CW+1)'(MAX_OUTSTANDING)) && (!r_wb_stb || !i_wb_stall);
        end
    end

    always_comb begin
        w_acc       = i_cmd_tvalid && o_cmd_tready;
        w_acc_set   = w_acc && w_is_set;
        w_acc_rw    = w_acc && (w_is_wr || w_is_rd);
        w_pop       = (r_res_cnt != '0) && i_cres_tready;
        w_push      = w_acc_set || w_term;
        w_push_op   = w_acc_set ? 3'b100 : (w_term_we ? 3'b010 : 3'b001);
        w_push_data = (w_term && !w_term_we) ? i_wb_dat : '0;
        w_out_next  = r_out + CW'(w_acc_rw) - CW'(w_term);
        w_stb_next  = w_acc_rw || (r_wb_stb && i_wb_stall);
    end

    always_ff @(posedge i_clk) begin
        if (w_acc_rw)
            r_tag_we[r_tag_wp] <= i_cmd_op_write_word;
        if (w_push) begin
            r_res_op[r_res_wp]   <= w_push_op;
            r_res_data[r_res_wp] <= w_push_data;
            r_res_err[r_res_wp]  <= w_term && i_wb_err;
            r_res_rty[r_res_wp]  <= w_term && i_wb_rty;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_addr    <= '0;
            r_out     <= '0;
            r_tag_wp  <= '0;
            r_tag_rp  <= '0;
            r_res_wp  <= '0;
            r_res_rp  <= '0;
            r_res_cnt <= '0;
            r_wb_cyc  <= 1'b0;
            r_wb_stb  <= 1'b0;
            r_wb_we   <= 1'b0;
            r_wb_adr  <= '0;
            r_wb_dat  <= '0;
            r_wb_sel  <= '0;
        end else begin
            if (w_acc_set)
                r_addr <= i_cmd_hw_addr;
            else if (w_acc_rw && i_cmd_inc)
                r_addr <= r_addr + ADDR_INC;
            if (w_acc_rw)
                r_tag_wp <= r_tag_wp + PW'(1);
            if (w_term)
                r_tag_rp <= r_tag_rp + PW'(1);
            if (w_push)
                r_res_wp <= r_res_wp + PW'(1);
            if (w_pop)
                r_res_rp <= r_res_rp + PW'(1);
            r_res_cnt <= r_res_cnt + CW'(w_push) - CW'(w_pop);
            r_out     <= w_out_next;
            r_wb_stb  <= w_stb_next;
            r_wb_cyc  <= w_stb_next || (w_out_next != '0);
            if (w_acc_rw) begin
                r_wb_we  <= i_cmd_op_write_word;
                r_wb_adr <= r_addr[SERIAL_ADDR_WIDTH-1:BYTE_ADDR_WIDTH];
                r_wb_dat <= i_cmd_op_write_word ? i_cmd_hw_data : '0;
                r_wb_sel <= '1;
            end
        end
    end

    assign o_wb_cyc = r_wb_cyc;
    assign o_wb_stb = r_wb_stb;
    assign o_wb_we  = r_wb_we;
    assign o_wb_adr = r_wb_adr;
    assign o_wb_dat = r_wb_dat;
    assign o_wb_sel = r_wb_sel;

    // Result payload is masked when empty so stale FIFO contents never reach the port.
    assign o_cres_tvalid         = (r_res_cnt != '0);
    assign o_cres_op_set_address = o_cres_tvalid && r_res_op[r_res_rp][2];
    assign o_cres_op_write_word  = o_cres_tvalid && r_res_op[r_res_rp][1];
    assign o_cres_op_read_word   = o_cres_tvalid && r_res_op[r_res_rp][0];
    assign o_cres_hw_data        = o_cres_tvalid ? r_res_data[r_res_rp] : '0;
    assign o_cres_bus_err        = o_cres_tvalid && r_res_err[r_res_rp];
    assign o_cres_bus_rty        = o_cres_tvalid && r_res_rty[r_res_rp];
endmodule

// File: tb/tb_wbcon_exec_pipe.sv
// Directed bench for wbcon_exec_pipe: pipelined slave model, result scoreboard
// and bus-issue scoreboard, all advanced from a single per-cycle task.
module tb_wbcon_exec_pipe;
    localparam int AW = 24, DW = 32, SW = 4, SAW = 26, MAXO = 4;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic           i_rst_n, i_cmd_tvalid, o_cmd_tready;
    logic           i_cmd_op_set_address, i_cmd_op_write_word, i_cmd_op_read_word, i_cmd_inc;
    logic [SAW-1:0] i_cmd_hw_addr;
    logic [DW-1:0]  i_cmd_hw_data;
    logic           o_cres_tvalid, i_cres_tready;
    logic           o_cres_op_set_address, o_cres_op_write_word, o_cres_op_read_word;
    logic [DW-1:0]  o_cres_hw_data;
    logic           o_cres_bus_err, o_cres_bus_rty;
    logic           o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]  o_wb_adr;
    logic [DW-1:0]  o_wb_dat;
    logic [SW-1:0]  o_wb_sel;
    logic           i_wb_stall, i_wb_ack, i_wb_err, i_wb_rty;
    logic [DW-1:0]  i_wb_dat;

    wbcon_exec_pipe #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_tvalid(i_cmd_tvalid), .o_cmd_tready(o_cmd_tready),
        .i_cmd_op_set_address(i_cmd_op_set_address), .i_cmd_op_write_word(i_cmd_op_write_word),
        .i_cmd_op_read_word(i_cmd_op_read_word), .i_cmd_inc(i_cmd_inc),
        .i_cmd_hw_addr(i_cmd_hw_addr), .i_cmd_hw_data(i_cmd_hw_data),
        .o_cres_tvalid(o_cres_tvalid), .i_cres_tready(i_cres_tready),
        .o_cres_op_set_address(o_cres_op_set_address), .o_cres_op_write_word(o_cres_op_write_word),
        .o_cres_op_read_word(o_cres_op_read_word), .o_cres_hw_data(o_cres_hw_data),
        .o_cres_bus_err(o_cres_bus_err), .o_cres_bus_rty(o_cres_bus_rty),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_wb_rty(i_wb_rty), .i_wb_dat(i_wb_dat)
    );

    typedef struct {
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] dat;
        int            cyc;
    } acc_t;

    int checks = 0, failures = 0;
    int cnt = 0, lat = 1, acc_at_first = -1;
    logic cmd_acc = 1'b0;
    logic [SAW-1:0] m_addr = '0;
    acc_t acc_q[$], pend_q[$], exp_bus[$];
    int   pend_due[$], kinds[$];
    logic [36:0] res_q[$];

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {8'hC3, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, update slave outputs after it.
    task automatic tick();
        acc_t a, e;
        int k;
        @(negedge i_clk);
        cmd_acc = i_cmd_tvalid && o_cmd_tready;
        if (!i_rst_n) begin
            pend_q.delete(); pend_due.delete();
        end else begin
            if (o_cres_tvalid && i_cres_tready) begin
                if (res_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
                else check("result", {27'b0, o_cres_op_set_address, o_cres_op_write_word,
                                      o_cres_op_read_word, o_cres_hw_data, o_cres_bus_err,
                                      o_cres_bus_rty}, {27'b0, res_q.pop_front()});
            end
            if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
                a.adr = o_wb_adr; a.we = o_wb_we; a.dat = o_wb_dat; a.cyc = cnt + 1;
                acc_q.push_back(a); pend_q.push_back(a); pend_due.push_back(cnt + lat);
                if (exp_bus.size() == 0) check("unexpected_strobe", 64'd1, 64'd0);
                else begin
                    e = exp_bus.pop_front();
                    check("strobe", {o_wb_sel, o_wb_we, o_wb_adr, (o_wb_we ? o_wb_dat : 32'h0)},
                          {4'hF, e.we, e.adr, (e.we ? e.dat : 32'h0)});
                end
            end
        end
        @(posedge i_clk); #1;
        cnt++;
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_rty = 1'b0; i_wb_dat = '0;
        if (i_rst_n && pend_q.size() > 0 && pend_due[0] <= cnt) begin
            a = pend_q.pop_front();
            void'(pend_due.pop_front());
            k = (kinds.size() > 0) ? kinds.pop_front() : 0;
            if (acc_at_first < 0) acc_at_first = acc_q.size();
            i_wb_ack = (k == 0); i_wb_err = (k == 1); i_wb_rty = (k == 2);
            i_wb_dat = (k == 0 && !a.we) ? pat(a.adr) : '0;
        end
    endtask

    // op = {set, write, read}; kind = 0 ack, 1 err, 2 rty
    task automatic send_cmd(input logic [2:0] op, input logic inc, input logic [SAW-1:0] haddr,
                            input logic [DW-1:0] data, input int kind);
        int n;
        acc_t e;
        n = 0;
        {i_cmd_op_set_address, i_cmd_op_write_word, i_cmd_op_read_word} = op;
        i_cmd_inc = inc; i_cmd_hw_addr = haddr; i_cmd_hw_data = data; i_cmd_tvalid = 1'b1;
        do begin tick(); n++; end while (!cmd_acc && n < 100);
        i_cmd_tvalid = 1'b0;
        check("cmd_accept", cmd_acc, 1'b1);
        if (cmd_acc) begin
            case (op)
                3'b100: begin res_q.push_back({3'b100, 32'h0, 2'b00}); m_addr = haddr; end
                3'b010, 3'b001: begin
                    e.adr = m_addr[SAW-1:2]; e.we = op[1]; e.dat = data; e.cyc = 0;
                    exp_bus.push_back(e);
                    kinds.push_back(kind);
                    res_q.push_back({op, (op[0] && kind == 0) ? pat(m_addr[SAW-1:2]) : 32'h0,
                                     kind == 1, kind == 2});
                    if (inc) m_addr = m_addr + 26'd4;
                end
                default: ;
            endcase
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((res_q.size() != 0 || pend_q.size() != 0) && n < 300) begin tick(); n++; end
        check({tag, "_drain"}, res_q.size(), 0);
        tick(); tick();
        check({tag, "_cyc_idle"}, o_wb_cyc, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_cmd_tvalid = 1'b0; i_cmd_op_set_address = 1'b0;
        i_cmd_op_write_word = 1'b0; i_cmd_op_read_word = 1'b0; i_cmd_inc = 1'b0;
        i_cmd_hw_addr = '0; i_cmd_hw_data = '0; i_cres_tready = 1'b1;
        i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_rty = 1'b0; i_wb_dat = '0;

        // reset state
        repeat (3) tick();
        check("rst_tready", o_cmd_tready, 1'b0);
        check("rst_outs", {o_wb_cyc, o_wb_stb, o_wb_we, o_cres_tvalid}, 4'b0);
        check("rst_bus", {o_wb_sel, o_wb_adr, o_wb_dat}, 64'h0);
        i_rst_n = 1'b1;
        tick();

        // set_address + 3 incrementing reads, zero-wait slave
        acc_q.delete(); lat = 1;
        send_cmd(3'b100, 1'b0, 26'h10, 32'h0, 0);
        send_cmd(3'b001, 1'b1, 26'h0, 32'h0, 0);
        send_cmd(3'b001, 1'b1, 26'h0, 32'h0, 0);
        send_cmd(3'b001, 1'b1, 26'h0, 32'h0, 0);
        wait_drain("t1");
        check("t1_nstrobes", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("t1_adr0", acc_q[0].adr, 24'h4);
            check("t1_adr2", acc_q[2].adr, 24'h6);
            check("t1_b2b", acc_q[2].cyc - acc_q[0].cyc, 2);
        end

        // 8 writes against a 6-cycle-late slave: credit caps in-flight at 4
        acc_q.delete(); lat = 6; acc_at_first = -1;
        for (int i = 0; i < 8; i++)
            send_cmd(3'b010, 1'b1, 26'h0, 32'hA000_0000 + i, 0);
        wait_drain("t2");
        check("t2_before_first_ack", acc_at_first, MAXO);
        check("t2_nstrobes", acc_q.size(), 8);

        // stall on the first strobe for 5 cycles
        acc_q.delete(); lat = 1; i_wb_stall = 1'b1;
        send_cmd(3'b010, 1'b0, 26'h0, 32'h1234_5678, 0);
        {i_cmd_op_set_address, i_cmd_op_write_word, i_cmd_op_read_word} = 3'b010;
        i_cmd_hw_data = 32'h9ABC_DEF0; i_cmd_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_hold", {o_wb_stb, o_wb_adr, o_wb_dat}, {1'b1, m_addr[SAW-1:2], 32'h1234_5678});
            check("t3_tready", o_cmd_tready, 1'b0);
            tick();
            check("t3_no_accept", cmd_acc, 1'b0);
        end
        i_wb_stall = 1'b0;
        send_cmd(3'b010, 1'b1, 26'h0, 32'h9ABC_DEF0, 0);
        wait_drain("t3");
        check("t3_nstrobes", acc_q.size(), 2);

        // err, rty, ack terminations stay in order
        send_cmd(3'b001, 1'b1, 26'h0, 32'h0, 1);
        send_cmd(3'b001, 1'b1, 26'h0, 32'h0, 2);
        send_cmd(3'b001, 1'b1, 26'h0, 32'h0, 0);
        wait_drain("t4");

        // result backpressure blocks issue once 4 results are queued
        i_cres_tready = 1'b0;
        for (int i = 0; i < 4; i++) send_cmd(3'b001, 1'b1, 26'h0, 32'h0, 0);
        repeat (6) tick();
        check("t5_cres_valid", o_cres_tvalid, 1'b1);
        {i_cmd_op_set_address, i_cmd_op_write_word, i_cmd_op_read_word} = 3'b001;
        i_cmd_tvalid = 1'b1;
        check("t5_tready_blocked", o_cmd_tready, 1'b0);
        tick();
        check("t5_no_accept", cmd_acc, 1'b0);
        i_cres_tready = 1'b1;
        send_cmd(3'b001, 1'b1, 26'h0, 32'h0, 0);
        wait_drain("t5");

        // illegal opcodes are consumed without result; address wraps
        send_cmd(3'b011, 1'b0, 26'h0, 32'h0, 0);
        send_cmd(3'b000, 1'b0, 26'h0, 32'h0, 0);
        send_cmd(3'b100, 1'b0, 26'h3FF_FFFC, 32'h0, 0);
        send_cmd(3'b001, 1'b1, 26'h0, 32'h0, 0);
        send_cmd(3'b001, 1'b1, 26'h0, 32'h0, 0);
        wait_drain("t6");

        // reset during an in-flight burst
        lat = 3;
        send_cmd(3'b100, 1'b0, 26'h100, 32'h0, 0);
        for (int i = 0; i < 3; i++) send_cmd(3'b001, 1'b1, 26'h0, 32'h0, 0);
        i_rst_n = 1'b0;
        tick();
        check("t7_rst_bus", {o_wb_cyc, o_wb_stb, o_cres_tvalid, o_cmd_tready}, 4'b0);
        res_q.delete(); exp_bus.delete(); kinds.delete(); m_addr = '0;
        tick();
        i_rst_n = 1'b1;
        lat = 1;
        send_cmd(3'b001, 1'b0, 26'h0, 32'h0, 0);
        send_cmd(3'b100, 1'b0, 26'h40, 32'h0, 0);
        send_cmd(3'b001, 1'b0, 26'h0, 32'h0, 0);
        wait_drain("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
